// File: rtl/wb_ram_if.sv
// Wishbone classic bus bundle between a master and the RAM responder.
// Clock and reset stay outside the bundle as plain ports.
interface wb_ram_if;
    logic [31:0] addr;
    logic [31:0] dat_w;
    logic [3:0]  sel;
    logic        cyc;
    logic        stb;
    logic        we;
    logic [31:0] dat_r;
    logic        ack;
    logic        err;

    modport master (
        output addr, dat_w, sel, cyc, stb, we,
        input  dat_r, ack, err
    );

    modport slave (
        input  addr, dat_w, sel, cyc, stb, we,
        output dat_r, ack, err
    );
endinterface

// File: rtl/wb_ram_slave.sv
// Wishbone classic responder: word RAM with range/alignment decode,
// programmable wait states and byte-lane writes.
module wb_ram_slave #(
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int          DEPTH_WORDS = 1024,
    parameter int          WAIT_STATES = 1
) (
    input logic      clk_i,
    input logic      rst_ni,
    wb_ram_if.slave  wbs
);
    localparam int          AW       = $clog2(DEPTH_WORDS);
    localparam logic [31:0] SPAN     = 32'(4 * DEPTH_WORDS);
    localparam logic [3:0]  CNT_INIT =
        (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;

    state_e        state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    logic [AW-1:0] idx_q, idx_d;
    logic          bad_q, bad_d;
    logic          we_q, we_d;
    logic [3:0]    sel_q, sel_d;
    logic [31:0]   wdat_q, wdat_d;
    logic          ack_q, ack_d;
    logic          err_q, err_d;
    logic [31:0]   rdat_q, rdat_d;
    logic [31:0]   mem_q [DEPTH_WORDS];

    logic [32:0]   req_diff;
    logic          req_bad;
    logic [AW-1:0] req_idx;
    logic          go_resp;

    // Borrow out of the 33-bit subtraction flags addresses below the base.
    always_comb begin
        req_diff = {1'b0, wbs.addr} - {1'b0, BASE_ADDR};
        req_bad  = (wbs.addr[1:0] != 2'b00) || req_diff[32]
                 || (req_diff[31:0] >= SPAN);
        req_idx  = req_diff[AW+1:2];
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        bad_d   = bad_q;
        we_d    = we_q;
        sel_d   = sel_q;
        wdat_d  = wdat_q;
        ack_d   = 1'b0;
        err_d   = 1'b0;
        rdat_d  = '0;
        go_resp = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (wbs.cyc && wbs.stb) begin
                    idx_d  = req_idx;
                    bad_d  = req_bad;
                    we_d   = wbs.we;
                    sel_d  = wbs.sel;
                    wdat_d = wbs.dat_w;
                    if (WAIT_STATES == 0) begin
                        state_d = RESP;
                        go_resp = 1'b1;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = CNT_INIT;
                    end
                end
            end
            WAIT: begin
                if (!wbs.cyc) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == 4'd0) begin
                    state_d = RESP;
                    go_resp = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP: state_d = IDLE;
            default: state_d = IDLE;
        endcase
        // Response outputs are registered on entry to RESP.
        if (go_resp) begin
            if (bad_d) begin
                err_d = 1'b1;
            end else begin
                ack_d = 1'b1;
                if (!we_d) rdat_d = mem_q[idx_d];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            bad_q   <= 1'b0;
            we_q    <= 1'b0;
            sel_q   <= '0;
            wdat_q  <= '0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            rdat_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            bad_q   <= bad_d;
            we_q    <= we_d;
            sel_q   <= sel_d;
            wdat_q  <= wdat_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
            rdat_q  <= rdat_d;
        end
    end

    // The write commits at the edge closing RESP, so reset can still cancel it.
    always_ff @(posedge clk_i) begin
        if (rst_ni && state_q == RESP && we_q && !bad_q) begin
            for (int b = 0; b < 4; b++) begin
                if (sel_q[b]) mem_q[idx_q][8*b +: 8] <= wdat_q[8*b +: 8];
            end
        end
    end

    assign wbs.dat_r = rdat_q;
    assign wbs.ack   = ack_q;
    assign wbs.err   = err_q;
endmodule
